alu_ram_sequencer: RTL and testbench

//  Batch controller for the ALU-RAM datapath. On start, walks all operand-ROM addresses.
//  Per address: fetches OP1/OP2 from the two operand ROMs, drives the ALU with one pass-wide

---
 rtl/alu_ram_sequencer_pkg.sv | 12 +
 rtl/alu_ram_sequencer_if.sv | 23 ++
 rtl/alu_ram_sequencer_wait_counter.sv | 19 +
 rtl/alu_ram_sequencer.sv | 70 +++++++
 tb/tb_alu_ram_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_ram_sequencer_pkg.sv
// alu_ram_sequencer_pkg: shared widths, ALU opcodes and sequencer state encoding
package alu_ram_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WRITE, DONE} state_t;
endpackage

// File: rtl/alu_ram_sequencer_if.sv
// alu_ram_sequencer_if: ROM/ALU/RAM datapath bus between sequencer and datapath
interface alu_ram_sequencer_if;
  import alu_ram_sequencer_pkg::*;
  logic en_ROM;
  logic [ADDR_W-1:0] addr_ROM;
  logic [DATA_W-1:0] rom_op1_d;
  logic [DATA_W-1:0] rom_op2_d;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0] alu_op;
  logic [DATA_W-1:0] alu_res;
  logic ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  modport master (
    output en_ROM, addr_ROM, alu_a, alu_b, alu_op, ram_we, ram_addr, ram_din,
    input rom_op1_d, rom_op2_d, alu_res
  );
  modport slave (
    input en_ROM, addr_ROM, alu_a, alu_b, alu_op, ram_we, ram_addr, ram_din,
    output rom_op1_d, rom_op2_d, alu_res
  );
endinterface

// File: rtl/alu_ram_sequencer_wait_counter.sv
// alu_ram_sequencer_wait_counter: loads LAT-1, counts down while enabled, flags zero
module alu_ram_sequencer_wait_counter #(
  parameter int LAT = 1
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic en,
  output logic expired
);
  localparam int W = LAT > 1 ? $clog2(LAT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(LAT - 1);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/alu_ram_sequencer.sv
// alu_ram_sequencer: walks all ROM addresses, runs each operand pair through the ALU, writes RAM
module alu_ram_sequencer
  import alu_ram_sequencer_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [OP_W-1:0] op_sel,
  alu_ram_sequencer_if.master bus,
  output logic busy,
  output logic done
);
  state_t state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0] op_q;
  logic expired;
  logic last;
  assign last = &addr;
  alu_ram_sequencer_wait_counter #(.LAT(ALU_LAT)) u_wait (
    .clk(clk),
    .rst(rst),
    .load(state == FETCH),
    .en(state == EXEC),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      op_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) op_q <= op_sel;
      if (state == FETCH) begin
        a_q <= bus.rom_op1_d;
        b_q <= bus.rom_op2_d;
      end
      if (state == EXEC && expired) res_q <= bus.alu_res;
      if (state == WRITE && !last) addr <= addr + 1'b1;
      if (state == DONE) addr <= '0;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? FETCH : IDLE;
      FETCH: nxt = EXEC;
      EXEC: nxt = expired ? WRITE : EXEC;
      WRITE: nxt = last ? DONE : FETCH;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign bus.en_ROM = state == FETCH;
  assign bus.addr_ROM = addr;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.alu_op = op_q;
  assign bus.ram_we = state == WRITE;
  assign bus.ram_addr = addr;
  assign bus.ram_din = res_q;
  assign busy = state == FETCH || state == EXEC || state == WRITE;
  assign done = state == DONE;
endmodule

// File: tb/tb_alu_ram_sequencer.sv
// tb_alu_ram_sequencer: table vectors, corner sequences and random passes against a pass-level model
module tb_alu_ram_sequencer;
  import alu_ram_sequencer_pkg::*;
  typedef struct {
    int c;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  typedef struct {
    logic [OP_W-1:0] op;
    int idx;
    logic [DATA_W-1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [OP_W-1:0] op_sel = '0;
  logic busy, done;
  logic dbusy;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] rom1 [16];
  logic [DATA_W-1:0] rom2 [16];
  wr_t wq[$];
  int dq[$];
  vec_t tv[7];
  alu_ram_sequencer_if bus ();
  alu_ram_sequencer #(.ALU_LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op_sel(op_sel),
    .bus(bus.master),
    .busy(busy),
    .done(done)
  );
  function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR: return a | b;
      OP_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction
  assign bus.rom_op1_d = bus.en_ROM ? rom1[bus.addr_ROM] : 32'hDEAD_BEEF;
  assign bus.rom_op2_d = bus.en_ROM ? rom2[bus.addr_ROM] : 32'hDEAD_BEEF;
  assign bus.alu_res = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.ram_we) wq.push_back('{c: cyc, a: bus.ram_addr, d: bus.ram_din});
    if (done) begin
      dq.push_back(cyc);
      dbusy = busy;
    end
  end
  task automatic chk(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic clear_log();
    wq.delete();
    dq.delete();
  endtask
  task automatic wait_writes(input int n, input string nm);
    int k = 0;
    while (wq.size() < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (wq.size() < n) chk({nm, "_timeout"}, 32'(wq.size()), 32'(n));
  endtask
  task automatic wait_done(input string nm);
    int k = 0;
    while (dq.size() == 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (dq.size() == 0) chk({nm, "_done_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
  endtask
  task automatic launch(input logic [OP_W-1:0] op, output int e);
    clear_log();
    @(negedge clk);
    op_sel = op;
    start = 1'b1;
    @(posedge clk);
    #1 e = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run_pass(input logic [OP_W-1:0] op, input string nm, output int e);
    launch(op, e);
    chk({nm, "_busy_fetch"}, 32'(busy), 1);
    chk({nm, "_en_rom_fetch"}, 32'(bus.en_ROM), 1);
    wait_done(nm);
  endtask
  task automatic check_pass(input string nm, input logic [OP_W-1:0] op, input int e);
    chk({nm, "_nwr"}, 32'(wq.size()), 16);
    chk({nm, "_ndone"}, 32'(dq.size()), 1);
    for (int i = 0; i < 16; i++) begin
      if (i < wq.size()) begin
        chk($sformatf("%s_addr%0d", nm, i), 32'(wq[i].a), 32'(i));
        chk($sformatf("%s_data%0d", nm, i), wq[i].d, alu_f(op, rom1[i], rom2[i]));
      end
    end
    if (wq.size() > 0) chk({nm, "_first_we"}, 32'(wq[0].c - e), 2);
    if (dq.size() > 0) begin
      chk({nm, "_done_cyc"}, 32'(dq[0] - e), 48);
      chk({nm, "_busy_at_done"}, 32'(dbusy), 0);
    end
  endtask
  initial begin
    int e, nz;
    logic [OP_W-1:0] rop;
    rom2 = '{32'h05, 32'h0A, 32'h0C, 32'h0F, 32'h14, 32'h1B, 32'h22, 32'h2D,
             32'h33, 32'h3C, 32'h47, 32'h50, 32'h5E, 32'h90, 32'h60, 32'h69};
    for (int i = 0; i < 16; i++) rom1[i] = 32'h100 * (i + 1) + i;
    tv[0] = '{OP_ADD, 0, 32'h105};
    tv[1] = '{OP_ADD, 15, 32'h1078};
    tv[2] = '{OP_SUB, 13, 32'hD7D};
    tv[3] = '{OP_AND, 3, 32'h3};
    tv[4] = '{OP_XOR, 3, 32'h40C};
    tv[5] = '{OP_OR, 15, 32'h106F};
    tv[6] = '{OP_SUB, 0, 32'hFB};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.en_ROM || bus.ram_we || busy || done || bus.addr_ROM != 0 || bus.ram_addr != 0 ||
          bus.alu_a != 0 || bus.alu_b != 0 || bus.alu_op != 0 || bus.ram_din != 0) nz++;
    end
    chk("reset_idle_outputs", 32'(nz), 0);
    chk("reset_ram_we", 32'(bus.ram_we), 0);
    chk("reset_busy", 32'(busy), 0);
    for (int v = 0; v < 7; v++) begin
      run_pass(tv[v].op, $sformatf("vec%0d", v), e);
      chk($sformatf("vec%0d_nwr", v), 32'(wq.size()), 16);
      if (wq.size() == 16) chk($sformatf("vec%0d_value", v), wq[tv[v].idx].d, tv[v].exp);
      if (v == 0) check_pass("vec0_full", tv[v].op, e);
    end
    launch(OP_ADD, e);
    wait_writes(8, "restart_ignored");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored");
    repeat (5) @(posedge clk);
    check_pass("restart_ignored", OP_ADD, e);
    launch(OP_ADD, e);
    wait_writes(5, "rst_mid");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ram_we", 32'(bus.ram_we), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_addr_rom", 32'(bus.addr_ROM), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", 32'(dq.size()), 0);
    chk("rst_mid_nwr", 32'(wq.size()), 5);
    run_pass(OP_ADD, "after_rst", e);
    check_pass("after_rst", OP_ADD, e);
    launch(OP_ADD, e);
    wait_writes(8, "op_change");
    op_sel = OP_SUB;
    wait_done("op_change");
    check_pass("op_change", OP_ADD, e);
    run_pass(OP_SUB, "sub_pass", e);
    if (wq.size() == 16) chk("sub_pass_addr13", wq[13].d, 32'hD7D);
    else chk("sub_pass_nwr", 32'(wq.size()), 16);
    clear_log();
    @(negedge clk);
    op_sel = OP_ADD;
    start = 1'b1;
    for (int k = 0; k < 300 && dq.size() < 2; k++) begin
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    chk("hold_nwr", 32'(wq.size()), 32);
    chk("hold_ndone", 32'(dq.size()), 2);
    if (dq.size() == 2) chk("hold_done_gap", 32'(dq[1] - dq[0]), 50);
    if (wq.size() == 32) begin
      chk("hold_pass1_addr3", wq[3].d, 32'h412);
      chk("hold_pass2_addr3", wq[19].d, 32'h412);
    end
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rom1[i] = $urandom;
      rop = 4'($urandom_range(0, 4));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_pass(rop, $sformatf("rand%0d", r), e);
      check_pass($sformatf("rand%0d", r), rop, e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
